mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified instruction/data memory between the IF stage (fetch, read-only)
//  and the MEM stage (load/store) of the 5-stage pipeline. Registered FSM grants one access at a time,

---
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/MEM request, response and memory handshake bundle for mem_port_arbiter
//
// Purpose : groups the IF fetch port, the MEM load/store port and the memory-side handshake.
// Modports: slave  - arbiter view (takes requests and ram_ack/rdata, drives responses and ram_*)
//           master - environment view (pipeline stages plus memory model)
// Signals : if_req_i/if_addr_i -> if_ready_o/if_rdata_o
//           mem_req_i/mem_we_i/mem_addr_i/mem_wdata_i/mem_be_i -> mem_ready_o/mem_rdata_o
//           ram_req_o/ram_we_o/ram_addr_o/ram_wdata_o/ram_be_o <- ram_ack_i/ram_rdata_i
//           busy_o
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req_i;
  logic [AW-1:0]   if_addr_i;
  logic            if_ready_o;
  logic [DW-1:0]   if_rdata_o;

  logic            mem_req_i;
  logic            mem_we_i;
  logic [AW-1:0]   mem_addr_i;
  logic [DW-1:0]   mem_wdata_i;
  logic [DW/8-1:0] mem_be_i;
  logic            mem_ready_o;
  logic [DW-1:0]   mem_rdata_o;

  logic            ram_req_o;
  logic            ram_we_o;
  logic [AW-1:0]   ram_addr_o;
  logic [DW-1:0]   ram_wdata_o;
  logic [DW/8-1:0] ram_be_o;
  logic            ram_ack_i;
  logic [DW-1:0]   ram_rdata_i;

  logic            busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_ready_o, if_rdata_o,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
    output mem_ready_o, mem_rdata_o,
    output ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o,
    input  ram_ack_i, ram_rdata_i,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_ready_o, if_rdata_o,
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
    input  mem_ready_o, mem_rdata_o,
    input  ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o,
    output ram_ack_i, ram_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-ported unified memory arbiter between IF fetch and MEM load/store
//
// Purpose : registered FSM (IDLE, BUSY_IF, BUSY_MEM, RESP) granting one memory access at a time.
//           MEM wins ties. RESP is a one-cycle gap so a request whose ready pulse is only now
//           visible to the pipeline cannot be granted a second time.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous reset, active-high
//           bus  - mem_port_arbiter_if.slave (IF port, MEM port, memory handshake, busy_o)
// Options : ARB_STARVE_GUARD_EN - after MAX_WAIT consecutive MEM grants that left IF waiting,
//           the next IDLE grant goes to IF. Undefined: fixed MEM priority.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY_IF, S_BUSY_MEM, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_grant_mem;
  logic            w_grant_if;
  logic            w_force_if;

  logic            r_if_ready;
  logic [DW-1:0]   r_if_rdata;
  logic            r_mem_ready;
  logic [DW-1:0]   r_mem_rdata;
  logic            r_ram_req;
  logic            r_ram_we;
  logic [AW-1:0]   r_ram_addr;
  logic [DW-1:0]   r_ram_wdata;
  logic [DW/8-1:0] r_ram_be;
  logic            r_busy;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] r_starve_cnt;

  // Only overrides MEM when IF is actually waiting.
  assign w_force_if = bus.if_req_i && (r_starve_cnt >= CW'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_if) begin
      r_starve_cnt <= '0;
    end else if (w_grant_mem && bus.if_req_i && (r_starve_cnt < CW'(MAX_WAIT))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_mem  = 1'b0;
    w_grant_if   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_req_i && !w_force_if) begin
          w_grant_mem  = 1'b1;
          w_state_next = S_BUSY_MEM;
        end else if (bus.if_req_i) begin
          w_grant_if   = 1'b1;
          w_state_next = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_MEM: begin
        if (bus.ram_ack_i) w_state_next = S_RESP;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output registers. Ready pulses are set on the ack edge and so live exactly in RESP;
  // ram_* buses keep their last values after the access, only ram_req_o drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_ready  <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= '0;
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_be    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_busy      <= (w_state_next != S_IDLE);
      if (w_grant_mem) begin
        r_ram_req   <= 1'b1;
        r_ram_we    <= bus.mem_we_i;
        r_ram_addr  <= bus.mem_addr_i;
        r_ram_wdata <= bus.mem_wdata_i;
        r_ram_be    <= bus.mem_we_i ? bus.mem_be_i : '1;
      end else if (w_grant_if) begin
        r_ram_req   <= 1'b1;
        r_ram_we    <= 1'b0;
        r_ram_addr  <= bus.if_addr_i;
        r_ram_be    <= '1;
      end
      if (r_state == S_BUSY_IF && bus.ram_ack_i) begin
        r_ram_req  <= 1'b0;
        r_if_rdata <= bus.ram_rdata_i;
        r_if_ready <= 1'b1;
      end
      if (r_state == S_BUSY_MEM && bus.ram_ack_i) begin
        r_ram_req   <= 1'b0;
        r_mem_ready <= 1'b1;
        // Stores leave the last load data in place.
        if (!r_ram_we) r_mem_rdata <= bus.ram_rdata_i;
      end
    end
  end

  assign bus.if_ready_o  = r_if_ready;
  assign bus.if_rdata_o  = r_if_rdata;
  assign bus.mem_ready_o = r_mem_ready;
  assign bus.mem_rdata_o = r_mem_rdata;
  assign bus.ram_req_o   = r_ram_req;
  assign bus.ram_we_o    = r_ram_we;
  assign bus.ram_addr_o  = r_ram_addr;
  assign bus.ram_wdata_o = r_ram_wdata;
  assign bus.ram_be_o    = r_ram_be;
  assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ram_req"},   64'(bus.ram_req_o),   64'd0);
    chk({tag, "_busy"},      64'(bus.busy_o),      64'd0);
    chk({tag, "_if_ready"},  64'(bus.if_ready_o),  64'd0);
    chk({tag, "_mem_ready"}, 64'(bus.mem_ready_o), 64'd0);
  endtask

  logic [9:0] exp_if_pat;

  initial begin
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_wdata_i = '0;
    bus.mem_be_i    = '0;
    bus.ram_ack_i   = 1'b0;
    bus.ram_rdata_i = '0;

    // Reset state
    #1;
    chk_idle_outs("rst");
    chk("rst_if_rdata",  64'(bus.if_rdata_o),  64'd0);
    chk("rst_mem_rdata", 64'(bus.mem_rdata_o), 64'd0);
    chk("rst_ram_addr",  64'(bus.ram_addr_o),  64'd0);
    chk("rst_ram_be",    64'(bus.ram_be_o),    64'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // 1: fetch only
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h100;
    cyc();
    chk("f_ram_req",  64'(bus.ram_req_o),  64'd1);
    chk("f_ram_addr", 64'(bus.ram_addr_o), 64'h100);
    chk("f_ram_we",   64'(bus.ram_we_o),   64'd0);
    chk("f_ram_be",   64'(bus.ram_be_o),   64'hF);
    chk("f_busy",     64'(bus.busy_o),     64'd1);
    chk("f_if_ready0", 64'(bus.if_ready_o), 64'd0);
    bus.ram_ack_i   = 1'b1;
    bus.ram_rdata_i = 32'h00500093;
    cyc();
    chk("f_if_ready", 64'(bus.if_ready_o), 64'd1);
    chk("f_if_rdata", 64'(bus.if_rdata_o), 64'h00500093);
    chk("f_ram_req_drop", 64'(bus.ram_req_o), 64'd0);
    chk("f_mem_ready", 64'(bus.mem_ready_o), 64'd0);
    bus.if_req_i  = 1'b0;
    bus.ram_ack_i = 1'b0;
    cyc();
    chk_idle_outs("f_end");
    chk("f_if_rdata_hold", 64'(bus.if_rdata_o), 64'h00500093);

    // 2: store with ack delayed 3 cycles
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = 1'b1;
    bus.mem_addr_i  = 32'h2004;
    bus.mem_wdata_i = 32'hDEADBEEF;
    bus.mem_be_i    = 4'h3;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s_ram_req%0d", i), 64'(bus.ram_req_o),   64'd1);
      chk($sformatf("s_addr%0d", i),    64'(bus.ram_addr_o),  64'h2004);
      chk($sformatf("s_wdata%0d", i),   64'(bus.ram_wdata_o), 64'hDEADBEEF);
      chk($sformatf("s_be%0d", i),      64'(bus.ram_be_o),    64'h3);
      chk($sformatf("s_we%0d", i),      64'(bus.ram_we_o),    64'd1);
      chk($sformatf("s_ready%0d", i),   64'(bus.mem_ready_o), 64'd0);
      if (i < 3) cyc();
    end
    bus.ram_ack_i   = 1'b1;
    bus.ram_rdata_i = 32'hCAFEF00D;
    cyc();
    chk("s_mem_ready", 64'(bus.mem_ready_o), 64'd1);
    chk("s_mem_rdata_unch", 64'(bus.mem_rdata_o), 64'd0);
    chk("s_ram_req_drop", 64'(bus.ram_req_o), 64'd0);
    chk("s_if_ready", 64'(bus.if_ready_o), 64'd0);
    bus.mem_req_i = 1'b0;
    bus.ram_ack_i = 1'b0;
    cyc();
    chk_idle_outs("s_end");

    // 3: collision - MEM load first, then IF
    bus.mem_req_i  = 1'b1;
    bus.mem_we_i   = 1'b0;
    bus.mem_addr_i = 32'h3000;
    bus.mem_be_i   = 4'h1;
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 32'h104;
    cyc();
    chk("c_addr_mem", 64'(bus.ram_addr_o), 64'h3000);
    chk("c_we_load",  64'(bus.ram_we_o),   64'd0);
    chk("c_be_load",  64'(bus.ram_be_o),   64'hF);
    bus.ram_ack_i   = 1'b1;
    bus.ram_rdata_i = 32'h11112222;
    cyc();
    chk("c_mem_ready", 64'(bus.mem_ready_o), 64'd1);
    chk("c_if_ready0", 64'(bus.if_ready_o),  64'd0);
    chk("c_mem_rdata", 64'(bus.mem_rdata_o), 64'h11112222);
    bus.mem_req_i = 1'b0;
    bus.ram_ack_i = 1'b0;
    cyc();
    chk("c_idle_gap_busy", 64'(bus.busy_o), 64'd0);
    chk("c_mem_ready_off", 64'(bus.mem_ready_o), 64'd0);
    cyc();
    chk("c_if_grant_req",  64'(bus.ram_req_o),  64'd1);
    chk("c_if_grant_addr", 64'(bus.ram_addr_o), 64'h104);
    bus.ram_ack_i   = 1'b1;
    bus.ram_rdata_i = 32'h33334444;
    cyc();
    chk("c_if_ready",  64'(bus.if_ready_o),  64'd1);
    chk("c_if_rdata",  64'(bus.if_rdata_o),  64'h33334444);
    chk("c_mem_ready1", 64'(bus.mem_ready_o), 64'd0);
    chk("c_mem_rdata_hold", 64'(bus.mem_rdata_o), 64'h11112222);
    bus.if_req_i  = 1'b0;
    bus.ram_ack_i = 1'b0;
    cyc();

    // 4: starvation, both requests held, memory acks immediately
`ifdef ARB_STARVE_GUARD_EN
    exp_if_pat = 10'b10_0001_0000;
`else
    exp_if_pat = 10'b00_0000_0000;
`endif
    bus.mem_req_i  = 1'b1;
    bus.mem_addr_i = 32'h4000;
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 32'h200;
    bus.ram_ack_i  = 1'b1;
    bus.ram_rdata_i = 32'h55556666;
    for (int k = 0; k < 10; k++) begin
      cyc();
      cyc();
      chk($sformatf("st_if%0d", k),  64'(bus.if_ready_o),  64'(exp_if_pat[k]));
      chk($sformatf("st_mem%0d", k), 64'(bus.mem_ready_o), 64'(!exp_if_pat[k]));
      cyc();
    end
    bus.mem_req_i = 1'b0;
    bus.if_req_i  = 1'b0;
    bus.ram_ack_i = 1'b0;
    cyc();

    // 5: reset mid-access
    bus.mem_req_i  = 1'b1;
    bus.mem_we_i   = 1'b1;
    bus.mem_addr_i = 32'h5000;
    cyc();
    chk("r_pre_req", 64'(bus.ram_req_o), 64'd1);
    rst = 1'b1;
    #1;
    chk_idle_outs("r_async");
    chk("r_if_rdata_clr", 64'(bus.if_rdata_o), 64'd0);
    bus.mem_req_i = 1'b0;
    bus.mem_we_i  = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    chk_idle_outs("r_after");
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h300;
    cyc();
    chk("r_fresh_addr", 64'(bus.ram_addr_o), 64'h300);
    bus.ram_ack_i   = 1'b1;
    bus.ram_rdata_i = 32'h77778888;
    cyc();
    chk("r_fresh_ready", 64'(bus.if_ready_o), 64'd1);
    chk("r_fresh_rdata", 64'(bus.if_rdata_o), 64'h77778888);
    bus.if_req_i = 1'b0;

    // 6: spurious ack held through RESP and into IDLE
    cyc();
    chk_idle_outs("sp_resp");
    cyc();
    chk_idle_outs("sp_idle");
    chk("sp_if_rdata_hold", 64'(bus.if_rdata_o), 64'h77778888);
    bus.ram_ack_i = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
